// File: rtl/pixel_lane_buffer.sv
// Packs a pixel stream into LANES-wide words, buffers them in a circular store
// and presents them through a registered output stage with optional lane reversal.
module pixel_lane_buffer #(
    parameter int PIX_W = 8,
    parameter int LANES = 4,
    parameter int DEPTH = 512
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      in_valid,
    input  logic [PIX_W-1:0]          in_data,
    input  logic                      in_last,
    output logic                      in_ready,
    input  logic                      rev_order,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*PIX_W-1:0]    out_data,
    output logic [LANES-1:0]          out_lane_en,
    output logic                      out_last,
    output logic [$clog2(DEPTH):0]    count
);

    // state   | meaning
    // O_EMPTY | output register empty, waiting for a stored word
    // O_READ  | synchronous store read in flight
    // O_VALID | output register holds a word, out_valid asserted

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(LANES);
    localparam int WW = LANES * PIX_W;
    localparam int MW = WW + LANES + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {O_EMPTY, O_READ, O_VALID} ostate_t;

    ostate_t         state_q, state_d;
    logic [LW-1:0]   lane_cnt;
    logic [WW-1:0]   pack_q;
    logic            ready_en;
    logic [CW-1:0]   wr_ptr, rd_ptr;
    logic [MW-1:0]   mem [DEPTH];
    logic [MW-1:0]   rd_word;
    logic            accept, commit, rd_issue, pop;
    logic [WW-1:0]   commit_data;
    logic [LANES-1:0] commit_en;
    logic [WW-1:0]   ld_data;
    logic [LANES-1:0] ld_en;
    logic [WW-1:0]   out_data_q;
    logic [LANES-1:0] out_en_q;
    logic            out_last_q;

    // The word sitting in the output register is still counted as stored.
    assign count     = (wr_ptr - rd_ptr) + CW'(state_q == O_VALID);
    assign in_ready  = ready_en && (count < DEPTH_C);
    assign accept    = in_valid && in_ready;
    assign commit    = accept && ((lane_cnt == LW'(LANES - 1)) || in_last);
    assign pop       = (state_q == O_VALID) && out_ready;
    assign out_valid = (state_q == O_VALID);
    assign out_data    = out_data_q;
    assign out_lane_en = out_en_q;
    assign out_last    = out_last_q;

    always_comb begin
        commit_data = pack_q;
        commit_en   = '0;
        for (int k = 0; k < LANES; k++) begin
            if (LW'(k) == lane_cnt)
                commit_data[k*PIX_W +: PIX_W] = in_data;
            commit_en[k] = (LW'(k) <= lane_cnt);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lane_cnt <= '0;
            pack_q   <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                if (commit) begin
                    lane_cnt <= '0;
                    pack_q   <= '0;
                end else begin
                    lane_cnt <= lane_cnt + LW'(1);
                    pack_q   <= commit_data;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (commit)
            mem[wr_ptr[AW-1:0]] <= {in_last, commit_en, commit_data};
        if (rd_issue)
            rd_word <= mem[rd_ptr[AW-1:0]];
    end

    // In O_VALID the held word is already out of the store, so only count>1
    // guarantees a word written on an earlier edge is ready to read.
    always_comb begin
        state_d  = state_q;
        rd_issue = 1'b0;
        case (state_q)
            O_EMPTY: begin
                if (count != '0) begin
                    state_d  = O_READ;
                    rd_issue = 1'b1;
                end
            end
            O_READ:  state_d = O_VALID;
            O_VALID: begin
                if (out_ready) begin
                    if (count > CW'(1)) begin
                        state_d  = O_READ;
                        rd_issue = 1'b1;
                    end else begin
                        state_d = O_EMPTY;
                    end
                end
            end
            default: state_d = O_EMPTY;
        endcase
    end

    always_comb begin
        ld_data = rd_word[WW-1:0];
        ld_en   = rd_word[WW +: LANES];
        if (rev_order) begin
            for (int k = 0; k < LANES; k++) begin
                ld_data[k*PIX_W +: PIX_W] = rd_word[(LANES-1-k)*PIX_W +: PIX_W];
                ld_en[k]                  = rd_word[WW + LANES - 1 - k];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= O_EMPTY;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_data_q <= '0;
            out_en_q   <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (commit)
                wr_ptr <= wr_ptr + CW'(1);
            if (state_q == O_READ) begin
                rd_ptr     <= rd_ptr + CW'(1);
                out_data_q <= ld_data;
                out_en_q   <= ld_en;
                out_last_q <= rd_word[MW-1];
            end
        end
    end

endmodule

// File: tb/tb_pixel_lane_buffer.sv
// Directed bench for pixel_lane_buffer with LANES=4, PIX_W=8, DEPTH=4.
module tb_pixel_lane_buffer;

    localparam int PIX_W = 8;
    localparam int LANES = 4;
    localparam int DEPTH = 4;

    logic                   CLK = 1'b0;
    logic                   RESET = 1'b0;
    logic                   in_valid = 1'b0;
    logic [PIX_W-1:0]       in_data = '0;
    logic                   in_last = 1'b0;
    logic                   in_ready;
    logic                   rev_order = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [LANES*PIX_W-1:0] out_data;
    logic [LANES-1:0]       out_lane_en;
    logic                   out_last;
    logic [$clog2(DEPTH):0] count;

    int total = 0;
    int bad   = 0;

    pixel_lane_buffer #(.PIX_W(PIX_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .rev_order(rev_order),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane_en(out_lane_en), .out_last(out_last), .count(count)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d,
                               input logic [3:0] en, input logic l);
        wait_valid();
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_data), 64'(d));
        chk({tag, "_en"}, 64'(out_lane_en), 64'(en));
        chk({tag, "_last"}, 64'(out_last), 64'(l));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        logic [31:0] w;

        // reset state
        tick(); tick(); tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_en", 64'(out_lane_en), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        RESET = 1'b1;
        #1;
        chk("rel_ready_before_edge", 64'(in_ready), 64'd0);
        tick();
        chk("rel_ready_after_edge", 64'(in_ready), 64'd1);

        // sequential fill + latency
        for (int i = 1; i <= 4; i++) push(8'(i), 1'b0);
        chk("lat_n0", 64'(out_valid), 64'd0);
        tick();
        chk("lat_n1", 64'(out_valid), 64'd0);
        tick();
        chk("lat_n2", 64'(out_valid), 64'd1);
        expect_word("seq_w0", 32'h04030201, 4'b1111, 1'b0);
        for (int i = 5; i <= 8; i++) push(8'(i), 1'b0);
        expect_word("seq_w1", 32'h08070605, 4'b1111, 1'b0);
        tick();
        chk("seq_count0", 64'(count), 64'd0);

        // partial word
        push(8'hAA, 1'b0);
        push(8'hBB, 1'b1);
        expect_word("part", 32'h0000BBAA, 4'b0011, 1'b1);

        // lane reversal, sampled at load
        rev_order = 1'b1;
        for (int i = 1; i <= 4; i++) push(8'(i), 1'b0);
        expect_word("rev_full", 32'h01020304, 4'b1111, 1'b0);
        push(8'hAA, 1'b0);
        push(8'hBB, 1'b1);
        wait_valid();
        rev_order = 1'b0;
        tick();
        expect_word("rev_part", 32'hAABB0000, 4'b1100, 1'b1);

        // full and wrap
        for (int r = 0; r < 4; r++) begin
            b = 8'(8'h10 + r * 16);
            for (int i = 0; i < 16; i++) push(8'(b + 8'(i)), 1'b0);
            chk("full_count", 64'(count), 64'd4);
            chk("full_ready", 64'(in_ready), 64'd0);
            if (r == 0) begin
                push(8'h99, 1'b0);
                chk("full_reject_count", 64'(count), 64'd4);
            end
            for (int j = 0; j < 4; j++) begin
                for (int l = 0; l < 4; l++) w[l*8 +: 8] = 8'(b + 8'(4 * j + l));
                expect_word("wrap", w, 4'b1111, 1'b0);
            end
            tick();
            chk("drain_count", 64'(count), 64'd0);
        end

        // backpressure
        for (int i = 1; i <= 8; i++) push(8'(8'h50 + 8'(i)), 1'b0);
        wait_valid();
        chk("bp_count", 64'(count), 64'd2);
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_data", 64'(out_data), 64'h54535251);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_pulse_count", 64'(count), 64'd1);
        expect_word("bp_w1", 32'h58575655, 4'b1111, 1'b0);

        // reset mid-frame
        for (int i = 0; i < 14; i++) push(8'(8'h60 + 8'(i)), 1'b0);
        chk("mid_count", 64'(count), 64'd3);
        RESET = 1'b0;
        #1;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        tick();
        RESET = 1'b1;
        tick();
        chk("mid_rel_ready", 64'(in_ready), 64'd1);
        push(8'h71, 1'b0);
        push(8'h72, 1'b1);
        expect_word("mid_after", 32'h00007271, 4'b0011, 1'b1);
        tick();
        chk("end_count", 64'(count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_lane_buffer.md
PIXEL_LANE_BUFFER -- requirements
Module: pixel_lane_buffer

Interface
REQ-001 The block SHALL have parameter PIX_W, default 8, meaning bits per pixel.
REQ-002 The block SHALL have parameter LANES, default 4, meaning pixels packed per word; legal values are 2 to 8.
REQ-003 The block SHALL have parameter DEPTH, default 512, meaning word capacity of the internal store; it SHALL be a power of 2.
REQ-004 The block SHALL have port CLK  input  1  meaning the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port RESET  input  1  meaning reset, asynchronous and active-low.
REQ-006 The block SHALL have port in_valid  input  1  meaning a pixel is offered.
REQ-007 The block SHALL have port in_data  input  PIX_W  meaning the offered pixel.
REQ-008 The block SHALL have port in_last  input  1  meaning the offered pixel ends the frame.
REQ-009 The block SHALL have port in_ready  output  1  meaning the block can accept a pixel.
REQ-010 The block SHALL have port rev_order  input  1  meaning lane order reversal on output.
REQ-011 The block SHALL have port out_valid  output  1  meaning out_data is valid.
REQ-012 The block SHALL have port out_ready  input  1  meaning the consumer accepts the word.
REQ-013 The block SHALL have port out_data  output  LANES*PIX_W  meaning the packed word; lane k occupies bits [k*PIX_W +: PIX_W].
REQ-014 The block SHALL have port out_lane_en  output  LANES  meaning a per-lane valid mask.
REQ-015 The block SHALL have port out_last  output  1  meaning the word ends the frame.
REQ-016 The block SHALL have port count  output  clog2(DEPTH)+1  meaning the number of stored words.

Function
REQ-017 A pixel SHALL be accepted on a cycle with in_valid=1 and in_ready=1, and not otherwise.
REQ-018 Packer: an accepted pixel SHALL be written to lane lane_cnt, lane_cnt SHALL count 0..LANES-1, and the first pixel SHALL go to lane 0.
REQ-019 A word SHALL commit to the store on acceptance when lane_cnt=LANES-1 or in_last=1, carrying the lane mask (lanes 0..lane_cnt set) and the last flag; lane_cnt SHALL then return to 0.
REQ-020 Unwritten lanes of a partial word SHALL read as 0.
REQ-021 in_ready SHALL equal (count < DEPTH).
REQ-022 The store SHALL be a circular buffer with read and write pointers of clog2(DEPTH)+1 bits; the extra bit disambiguates full from empty, and pointers SHALL wrap from DEPTH-1 to 0.
REQ-023 On a simultaneous commit and pop, count SHALL be unchanged.
REQ-024 The output FSM SHALL have three states, O_EMPTY, O_READ and O_VALID.
REQ-025 O_EMPTY SHALL go to O_READ when count>0, issuing a synchronous memory read.
REQ-026 O_READ SHALL go to O_VALID after one cycle, loading the output register and advancing the read pointer.
REQ-027 O_VALID SHALL hold out_data, out_lane_en and out_last stable until out_valid=1 and out_ready=1.
REQ-028 On that transfer, O_VALID SHALL go to O_READ if count>0 after the pop, else to O_EMPTY.
REQ-029 Latency: a word committed at edge N into an empty, idle block SHALL show out_valid=1 after edge N+2.
REQ-030 Throughput: the output SHALL sustain one word per 2 cycles.
REQ-031 rev_order SHALL be sampled at output-register load, not afterwards.
REQ-032 When rev_order=1, output lane k SHALL carry stored lane LANES-1-k, and out_lane_en SHALL be reversed identically.
REQ-033 out_valid SHALL be 1 only in O_VALID.
REQ-034 A word-completing pixel SHALL never be accepted while count=DEPTH, so the store SHALL never overflow.

Reset
REQ-035 While RESET=0, the block SHALL force lane_cnt=0, pointers=0, count=0 and state O_EMPTY.
REQ-036 While RESET=0, the block SHALL drive out_valid=0, out_data=0, out_lane_en=0, out_last=0 and in_ready=0.
REQ-037 Reset mid-frame SHALL discard both the partial word and all stored words.
REQ-038 in_ready SHALL rise on the first clock edge after RESET deasserts.

Verification
REQ-039 Sequential fill: with LANES=4, send pixels 0x01..0x08 with out_ready=1 -> words 0x04030201 then 0x08070605, each with out_lane_en=4'b1111 and out_last=0.
REQ-040 Partial word: send 0xAA, 0xBB with in_last=1 on 0xBB -> out_data=0x0000BBAA, out_lane_en=4'b0011, out_last=1.
REQ-041 Lane reversal: send 0x01..0x04 with rev_order=1 -> out_data=0x01020304; the same word with out_lane_en=4'b0011 becomes 4'b1100.
REQ-042 Full and wrap: with DEPTH=4 and out_ready=0, send 16 pixels -> count=4 and in_ready=0; then drain and refill 3 more times -> data in order across the pointer wrap.
REQ-043 Backpressure: hold out_ready=0 for 5 cycles while out_valid=1 -> out_data stays stable; pulse out_ready for 1 cycle -> count decrements by 1.
REQ-044 Reset mid-frame: after 2 pixels plus 3 stored words, pulse RESET=0 -> count=0 and out_valid=0; the next pixel lands in lane 0.
